uart_tx8: RTL and testbench
===========================

UART_TX8 -- requirements
Module: uart_tx8

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 res  input  1  reset, asynchronous, active-high.
REQ-004 data_In  input  8  byte to transmit, sampled only at acceptance.
REQ-005 en  input  1  load request; a byte is accepted on a rising clk edge where en=1 and ready=1.
REQ-006 ready  output  1  high only in IDLE; the block can accept a byte.
REQ-007 busy  output  1  high from the cycle after acceptance until the end of the stop bit.
REQ-008 tx  output  1  serial line; idle level 1.

Function
REQ-009 States: IDLE, START, DATA, PARITY (compiled in only per REQ-024), STOP; all outputs are registered.
REQ-010 IDLE: tx=1, ready=1, busy=0; on acceptance, capture data_In into an internal shift register, clear the bit counter and the baud counter, and go to START.
REQ-011 tx goes low on the first cycle after the acceptance edge; every bit, start included, is held exactly CLKS_PER_BIT cycles.
REQ-012 START -> DATA after CLKS_PER_BIT cycles; DATA sends bits 0..7 LSB first, one per CLKS_PER_BIT cycles.
REQ-013 After bit 7: go to PARITY if it is compiled in, else to STOP; STOP drives tx=1 for CLKS_PER_BIT cycles, then returns to IDLE.
REQ-014 Frame length is 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity), measured from the first tx=0 cycle to the first IDLE cycle.
REQ-015 en while ready=0 is ignored and not queued; changes on data_In after acceptance do not affect the frame in flight.
REQ-016 With en held high continuously: ready=1 for exactly one cycle between frames, and the next frame is accepted on that cycle.
REQ-017 Acceptance-to-acceptance spacing with en held high is therefore 10*CLKS_PER_BIT+1 cycles (11*CLKS_PER_BIT+1 with parity).
REQ-018 Baud counter width is ceil(log2(CLKS_PER_BIT)); it wraps to 0 at CLKS_PER_BIT-1, and the state or bit advance happens on that same edge.
REQ-019 The bit counter is 3 bits; DATA exits when the counter reads 7 at the baud wrap.

Reset
REQ-020 Asserting res forces, immediately and without a clock edge: state=IDLE, tx=1, ready=1, busy=0, and all counters and the shift register to 0.
REQ-021 Reset mid-frame aborts the frame with no partial stop bit; after res deasserts, the first clk edge with en=1 starts a fresh frame.
REQ-022 en is ignored while res=1.

Configuration
REQ-023 Macro UART_TX8_PARITY_EN selects whether a parity bit is sent.
REQ-024 UART_TX8_PARITY_EN defined: PARITY state inserted between DATA and STOP; tx = XOR of the 8 data bits (even parity), held CLKS_PER_BIT cycles.
REQ-025 UART_TX8_PARITY_EN undefined: no PARITY state and no parity logic; DATA goes directly to STOP.

Structure
REQ-026 Shared package uart_pkg holds: the state enum (IDLE, START, DATA, PARITY, STOP), DATA_BITS=8, STOP_BITS=1, and the frame-length constants used by the bench.
REQ-027 One sub-module, baud_div (parameter CLKS_PER_BIT; inputs clk, res, clear; output tick), generates the bit-period strobe.
REQ-028 The FSM, shift register and bit counter stay in uart_tx8.

Verification (CLKS_PER_BIT=4)
REQ-029 Reset-then-idle: res pulse, no en -> tx=1, ready=1, busy=0 on every cycle.
REQ-030 Single byte: data_In=8'hA5 with a one-cycle en -> tx over the next 40 cycles = 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 cycles; ready back to 1 at cycle 41.
REQ-031 Back-to-back: en held high, data 8'h00 then 8'hFF -> acceptances 41 cycles apart and exactly one ready=1 cycle between the frames.
REQ-032 Ignored load: en pulse with data_In=8'h3C during bit 2 of an 8'h81 frame -> the 8'h81 frame completes unchanged, and 8'h3C is never transmitted.
REQ-033 Mid-frame reset: res asserted during bit 4 between clk edges -> tx=1 and ready=1 with no clock edge; the next en with 8'h55 sends a clean full frame.
REQ-034 Parity build: with UART_TX8_PARITY_EN defined, 8'h07 -> parity bit 1 and 8'h03 -> parity bit 0; frame is 44 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and frame constants for the 8-bit UART transmitter.
// Honours macro UART_TX8_PARITY_EN (adds one even-parity bit per frame).
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned STOP_BITS = 1;

`ifdef UART_TX8_PARITY_EN
   localparam int unsigned PARITY_BITS = 1;
`else
   localparam int unsigned PARITY_BITS = 0;
`endif

   // start + data + optional parity + stop
   localparam int unsigned FRAME_BITS = 1 + DATA_BITS + PARITY_BITS + STOP_BITS;

   function automatic int unsigned frame_cycles(input int unsigned clks_per_bit);
      return FRAME_BITS * clks_per_bit;
   endfunction

endpackage

// File: rtl/uart_tx8_if.sv
// Load handshake and serial output of uart_tx8, grouped as one bundle.
// Signal set is identical with or without UART_TX8_PARITY_EN.
interface uart_tx8_if;

   logic [7:0] data_In;
   logic       en;
   logic       ready;
   logic       busy;
   logic       tx;

   modport master (
      output data_In,
      output en,
      input  ready,
      input  busy,
      input  tx
   );

   modport slave (
      input  data_In,
      input  en,
      output ready,
      output busy,
      output tx
   );

endinterface

// File: rtl/baud_div.sv
// Bit-period strobe: tick is high on the last cycle of each CLKS_PER_BIT window.
// Independent of UART_TX8_PARITY_EN.
module baud_div #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic res,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         cnt <= '0;
      end else if (clear || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/uart_tx8.sv
// 8N1 UART transmitter with registered outputs; define UART_TX8_PARITY_EN
// to insert an even-parity bit between the data bits and the stop bit.
module uart_tx8
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic        clk,
   input  logic        res,
   uart_tx8_if.slave   bus
);

   state_t     state, state_n;
   logic [7:0] shreg, shreg_n;
   logic [2:0] bitcnt, bitcnt_n;
   logic       tick;
   logic       baud_clear;
   logic       tx_n;
`ifdef UART_TX8_PARITY_EN
   logic       par, par_n;
`endif

   // Holding the divider clear in IDLE makes the acceptance edge restart the bit period.
   assign baud_clear = (state == IDLE);

   baud_div #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk   (clk),
      .res   (res),
      .clear (baud_clear),
      .tick  (tick)
   );

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state     <= IDLE;
         shreg     <= '0;
         bitcnt    <= '0;
         bus.tx    <= 1'b1;
         bus.ready <= 1'b1;
         bus.busy  <= 1'b0;
`ifdef UART_TX8_PARITY_EN
         par       <= 1'b0;
`endif
      end else begin
         state     <= state_n;
         shreg     <= shreg_n;
         bitcnt    <= bitcnt_n;
         bus.tx    <= tx_n;
         bus.ready <= (state_n == IDLE);
         bus.busy  <= (state_n != IDLE);
`ifdef UART_TX8_PARITY_EN
         par       <= par_n;
`endif
      end
   end

   always_comb begin
      state_n  = state;
      shreg_n  = shreg;
      bitcnt_n = bitcnt;
`ifdef UART_TX8_PARITY_EN
      par_n    = par;
`endif
      case (state)
         IDLE: begin
            if (bus.en) begin
               shreg_n  = bus.data_In;
               bitcnt_n = '0;
`ifdef UART_TX8_PARITY_EN
               par_n    = ^bus.data_In;
`endif
               state_n  = START;
            end
         end
         START: begin
            if (tick) state_n = DATA;
         end
         DATA: begin
            if (tick) begin
               shreg_n  = {1'b0, shreg[7:1]};
               bitcnt_n = bitcnt + 3'd1;
               if (bitcnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX8_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end
            end
         end
`ifdef UART_TX8_PARITY_EN
         PARITY: begin
            if (tick) state_n = STOP;
         end
`endif
         STOP: begin
            if (tick) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      // Output is decoded from the next state so tx changes on the same edge as the state.
      tx_n = 1'b1;
      case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = shreg_n[0];
`ifdef UART_TX8_PARITY_EN
         PARITY:  tx_n = par_n;
`endif
         default: tx_n = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx8.sv
// Scoreboard bench for uart_tx8 at CLKS_PER_BIT=4; frame length follows
// UART_TX8_PARITY_EN through uart_pkg.
module tb_uart_tx8;
   import uart_pkg::*;

   localparam int unsigned N         = 4;
   localparam int unsigned FRAME_CYC = FRAME_BITS * N;

   logic clk = 1'b0;
   logic res;

   uart_tx8_if bus();

   uart_tx8 #(.CLKS_PER_BIT(N)) dut (
      .clk (clk),
      .res (res),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int unsigned cycle  = 0;
   int          frames_seen = 0;
   bit          in_frame = 1'b0;
   logic [8:0]  exp_q[$];

   always @(posedge clk) cycle <= cycle + 1;

   task automatic compare(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Expected tx waveform, one bit per cycle; p is the hand-computed parity bit.
   function automatic logic [63:0] make_wave(input logic [7:0] d, input logic p);
      logic [63:0] w;
      logic        b;
      w = '1;
      for (int unsigned k = 0; k < FRAME_BITS; k++) begin
         if (k == 0)                           b = 1'b0;
         else if (k <= 8)                      b = d[k-1];
         else if (PARITY_BITS == 1 && k == 9)  b = p;
         else                                  b = 1'b1;
         for (int unsigned c = 0; c < N; c++) w[k*N + c] = b;
      end
      return w;
   endfunction

   // Monitor: captures each frame from its first tx=0 cycle and checks it against the queue head.
   initial begin : monitor
      logic [63:0] wave;
      logic [63:0] mask;
      logic [8:0]  cur;
      bit          have_exp;
      bit          hs_ok;
      int unsigned idx;
      mask = (64'd1 << FRAME_CYC) - 64'd1;
      wave = '0;
      cur = '0;
      have_exp = 1'b0;
      hs_ok = 1'b0;
      idx = 0;
      forever begin
         @(negedge clk);
         if (res === 1'b1) begin
            in_frame = 1'b0;
            exp_q.delete();
         end else if (in_frame) begin
            if (idx < FRAME_CYC) begin
               wave[idx] = bus.tx;
               if (!(bus.ready === 1'b0 && bus.busy === 1'b1)) hs_ok = 1'b0;
               idx++;
            end else begin
               if (have_exp) begin
                  compare($sformatf("frame_%02h", cur[7:0]), wave & mask,
                          make_wave(cur[7:0], cur[8]) & mask);
                  compare($sformatf("frame_%02h_handshake", cur[7:0]), 64'(hs_ok), 64'd1);
               end
               compare("first_idle_cycle", {bus.tx, bus.ready, bus.busy}, 3'b110);
               frames_seen++;
               in_frame = 1'b0;
            end
         end else if (bus.tx === 1'b0) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               have_exp = 1'b0;
               $display("FAIL unexpected_frame: actual=frame_start required=idle (t=%0t)", $time);
            end else begin
               cur = exp_q.pop_front();
               have_exp = 1'b1;
            end
            wave = '1;
            wave[0] = bus.tx;
            hs_ok = (bus.ready === 1'b0 && bus.busy === 1'b1);
            idx = 1;
            in_frame = 1'b1;
         end
      end
   end

   // Waits for acceptance (bounded), pushes the expected frame, returns the acceptance cycle.
   task automatic accept(input logic [7:0] d, input logic p, output int unsigned acc);
      int unsigned n;
      n = 0;
      bus.data_In = d;
      bus.en = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!(bus.ready === 1'b1 && res === 1'b0) && n < 300);
      if (n >= 300) begin
         checks++;
         errors++;
         acc = 0;
         $display("FAIL accept_timeout: actual=no_ready required=ready data=%02h", d);
      end else begin
         acc = cycle;
         exp_q.push_back({p, d});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic gap();
      repeat (FRAME_CYC + 3) @(posedge clk);
      #1;
   endtask

   initial begin : stimulus
      int unsigned a0, a1, a2, a3, a4, a5, a6, a7, rel;
      res = 1'b1;
      bus.en = 1'b0;
      bus.data_In = 8'h00;
      #1 compare("reset_state", {bus.tx, bus.ready, bus.busy}, 3'b110);
      repeat (3) @(posedge clk);
      #1 res = 1'b0;

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         compare("idle_after_reset", {bus.tx, bus.ready, bus.busy}, 3'b110);
      end
      @(posedge clk);
      #1;

      // Single byte, data_In disturbed right after acceptance.
      accept(8'hA5, 1'b0, a0);
      bus.en = 1'b0;
      bus.data_In = 8'hFF;
      gap();

      // Back-to-back with en held high.
      accept(8'h00, 1'b0, a1);
      accept(8'hFF, 1'b0, a2);
      bus.en = 1'b0;
      compare("b2b_spacing", 64'(a2 - a1), 64'(FRAME_CYC + 1));
      gap();

      // Load attempt during bit 2 of an 8'h81 frame.
      accept(8'h81, 1'b0, a3);
      bus.en = 1'b0;
      repeat (13) @(posedge clk);
      #1;
      bus.data_In = 8'h3C;
      bus.en = 1'b1;
      compare("ready_low_midframe", bus.ready, 1'b0);
      @(posedge clk);
      #1 bus.en = 1'b0;
      repeat (FRAME_CYC + 20) @(posedge clk);
      #1;

      // Asynchronous reset during bit 4 of an 8'h0F frame (tx is low there).
      accept(8'h0F, 1'b0, a4);
      bus.en = 1'b0;
      repeat (21) @(posedge clk);
      #1 compare("tx_before_reset", bus.tx, 1'b0);
      #2 res = 1'b1;
      #1 compare("async_reset_outputs", {bus.tx, bus.ready, bus.busy}, 3'b110);
      bus.data_In = 8'h3C;
      bus.en = 1'b1;
      repeat (2) @(posedge clk);
      #1 compare("en_ignored_in_reset", {bus.tx, bus.ready, bus.busy}, 3'b110);
      res = 1'b0;
      rel = cycle;
      accept(8'h55, 1'b0, a5);
      bus.en = 1'b0;
      compare("first_edge_after_reset", 64'(a5), 64'(rel));
      gap();

      // Parity patterns: 8'h07 has odd weight, 8'h03 even.
      accept(8'h07, 1'b1, a6);
      bus.en = 1'b0;
      gap();
      accept(8'h03, 1'b0, a7);
      bus.en = 1'b0;
      gap();

      for (int i = 0; i < 500 && (exp_q.size() != 0 || in_frame); i++) @(posedge clk);
      #1;
      compare("queue_drained", 64'(exp_q.size()), 64'd0);
      compare("frames_seen", 64'(frames_seen), 64'd7);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
